exu_mdu: RTL and testbench
==========================

Name: exu_mdu

Overview:
- Parametrised multi-cycle multiply/divide execute unit for the RV32M/RV64M extension.
- Sits beside the core execute stage. The execute stage issues an M-type op with two operands, stalls while the unit is busy, and collects one result pulse per accepted request.
- Uses the same reqValid/respValid pulse handshake and perf-event outputs as the rest of the pipeline.
- Generalises width (XLEN) and per-cycle throughput (bits retired per iteration); adds kill/flush and RISC-V corner-case handling.

Parameters:
- XLEN, 32, operand/result width; 32 or 64.
- MUL_BITS, 1, multiplier bits consumed per cycle; power of 2, divides XLEN, range 1..XLEN.
- DIV_BITS, 1, quotient bits produced per cycle; 1 or 2.

Ports:
- clock  input  1  system clock
- reset  input  1  reset
- reqValid  input  1  request strobe; sampled only when reqReady=1
- reqReady  output  1  unit can accept a request this cycle
- kill  input  1  flush; abort any in-flight op
- op  input  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- lhs  input  XLEN  rs1 value
- rhs  input  XLEN  rs2 value
- respValid  output  1  result valid, one-cycle pulse
- res  output  XLEN  result; stable from the respValid cycle until the next accept
- is_mdu_wait  output  1  perf: unit busy (MUL or DIV state)
- is_mul_seen  output  1  perf: respValid for ops 0-3
- is_div_seen  output  1  perf: respValid for ops 4-7

Behaviour:
- Reset: asynchronous, active-high, on reset. Clock is clock.
- Reset values: state=MDU_RESET, reqReady=0, respValid=0, res=0, all perf outputs=0.
- States: MDU_RESET, MDU_IDLE, MDU_MUL, MDU_DIV, MDU_DONE.
- MDU_RESET -> MDU_IDLE unconditionally after one cycle.
- reqReady = (state==MDU_IDLE) | (state==MDU_DONE). Back-to-back issue is allowed from DONE.
- Accept = reqValid & reqReady & ~kill. On accept, latch op, operand magnitudes, and sign flags.
- Accept with op<4 -> MDU_MUL.
- Accept with op>=4, normal case -> MDU_DIV.
- Accept with op>=4, special case -> MDU_DONE directly. Special cases:
  - rhs==0: quotient all-ones; remainder = lhs.
  - Signed overflow (DIV/REM, lhs = 0x8..0, rhs = all-ones): quotient = lhs; remainder = 0.
- MDU_MUL: shift-add over a 2*XLEN product, MUL_BITS multiplier bits per cycle. Exactly NM = XLEN/MUL_BITS cycles, then -> MDU_DONE.
- MDU_DIV: restoring division, DIV_BITS quotient bits per cycle. Exactly ND = XLEN/DIV_BITS cycles, then -> MDU_DONE.
- Latency, with accept in cycle T:
  - MUL ops: respValid in cycle T+NM+1.
  - DIV ops: respValid in cycle T+ND+1.
  - Special cases: respValid in cycle T+1.
- MDU_DONE: respValid=1 for exactly one cycle.
  - With a new accept in the same cycle -> MUL/DIV/DONE as above.
  - Otherwise -> MDU_IDLE.
- Sign handling: operate on magnitudes; apply negation on entry to MDU_DONE (the register that drives res).
  - MULH: signed x signed; MULHSU: signed x unsigned; MULHU: unsigned.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
  - Quotient sign = sign(lhs) XOR sign(rhs). Remainder sign = sign(lhs).
- res is registered. It updates only on entry to MDU_DONE and holds otherwise, including through IDLE and the next op's busy cycles.
- kill in any state except MDU_RESET:
  - next state = MDU_IDLE; respValid is not asserted for the aborted op.
  - kill in the same cycle as reqValid: the request is dropped.
  - kill during MDU_DONE: that cycle's respValid still asserts (the result already completed); any new request in that cycle is dropped.
- Reset mid-operation: immediate abort to MDU_RESET; no respValid.
- is_mdu_wait = state in {MDU_MUL, MDU_DIV}.
- No other states are reachable. An illegal encoding recovers to MDU_IDLE.

Test Plan:
- Reset, release; reqValid=1, op=MUL, lhs=7, rhs=6 (XLEN=32, MUL_BITS=1) -> reqReady=0 for the 32 busy cycles; respValid one pulse at T+33; res=42; is_mul_seen=1 in the same cycle.
- op=MULH, lhs=0xFFFFFFFF, rhs=0xFFFFFFFF -> res=0. op=MULHU with the same operands -> res=0xFFFFFFFE. op=MULHSU, lhs=0xFFFFFFFF, rhs=2 -> res=0xFFFFFFFF.
- op=DIV, lhs=-7 (0xFFFFFFF9), rhs=2 -> res=0xFFFFFFFD at T+33. op=REM with the same operands -> res=0xFFFFFFFF. Repeat with DIV_BITS=2 -> respValid at T+17.
- Corner cases:
  - DIVU 5/0 -> res=0xFFFFFFFF at T+1.
  - REMU 5/0 -> res=5.
  - DIV 0x80000000 / 0xFFFFFFFF -> res=0x80000000 at T+1.
  - REM with the same operands -> res=0.
- Issue DIV 100/3; assert kill at T+10 -> state IDLE at T+11; no respValid. Then issue MUL 3*3 -> res=9; the previous res value is unchanged until this op's DONE.
- Back-to-back: issue a new op with reqValid in the respValid cycle -> accepted with no idle bubble. Assert reset mid-MUL at T+5 -> reqReady/respValid=0 immediately; reqReady=1 two cycles after release.

Source files
------------

// File: rtl/exu_mdu.sv
// exu_mdu: multi-cycle RV32M/RV64M multiply/divide execute unit.
// The unit multiplies by shift-add, MUL_BITS multiplier bits per cycle. It divides by
// restoring division, DIV_BITS quotient bits per cycle. Both operate on operand magnitudes.
// The sign is fixed up when the result is loaded into the res register.
module exu_mdu #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_BITS = 1,
    parameter int unsigned DIV_BITS = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            reqValid,
    output logic            reqReady,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] lhs,
    input  logic [XLEN-1:0] rhs,
    output logic            respValid,
    output logic [XLEN-1:0] res,
    output logic            is_mdu_wait,
    output logic            is_mul_seen,
    output logic            is_div_seen
);

    localparam int unsigned NM = XLEN / MUL_BITS;
    localparam int unsigned ND = XLEN / DIV_BITS;
    localparam int unsigned CW = $clog2(XLEN + 1);

    typedef enum logic [2:0] {
        MDU_RESET = 3'd0,
        MDU_IDLE  = 3'd1,
        MDU_MUL   = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DONE  = 3'd4
    } mdu_state_e;

    mdu_state_e        state_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   dvsr_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   res_q;

    // Operand decode for a request presented this cycle
    logic            lhs_signed, rhs_signed, lhs_neg, rhs_neg;
    logic [XLEN-1:0] lhs_mag, rhs_mag;
    logic            div_zero, div_ovf, special, req_neg;
    logic [XLEN-1:0] special_res;

    // Decode signedness, magnitudes and the divide corner cases of the incoming request
    always_comb begin
        lhs_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        rhs_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        lhs_neg    = lhs_signed & lhs[XLEN-1];
        rhs_neg    = rhs_signed & rhs[XLEN-1];
        lhs_mag    = lhs_neg ? (~lhs + 1'b1) : lhs;
        rhs_mag    = rhs_neg ? (~rhs + 1'b1) : rhs;
        div_zero   = (rhs == '0);
        div_ovf    = ~op[0] & (lhs == {1'b1, {(XLEN-1){1'b0}}}) & (rhs == '1);
        special    = op[2] & (div_zero | div_ovf);
        // Remainder takes the dividend's sign; everything else the XOR of both
        req_neg    = (op[2] & op[1]) ? lhs_neg : (lhs_neg ^ rhs_neg);
        if (div_zero) begin
            special_res = op[1] ? lhs : '1;
        end else begin
            special_res = op[1] ? '0 : lhs;
        end
    end

    // Multiply step: add mcand * (low MUL_BITS of multiplier) into the high half, shift right
    logic [XLEN+MUL_BITS-1:0] mul_add, mul_acc;
    logic [2*XLEN-1:0]        prod_nxt, prod_fin;
    logic [XLEN-1:0]          mul_res;

    // Form the partial product and the signed-corrected result of this step
    always_comb begin
        mul_add = '0;
        for (int i = 0; i < int'(MUL_BITS); i++) begin
            if (prod_q[i]) begin
                mul_add = mul_add + ({{MUL_BITS{1'b0}}, mcand_q} << i);
            end
        end
        mul_acc  = {{MUL_BITS{1'b0}}, prod_q[2*XLEN-1:XLEN]} + mul_add;
        prod_fin = neg_q ? (~prod_nxt + 1'b1) : prod_nxt;
        mul_res  = (op_q[1:0] == 2'd0) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
    end

    // A full-width step consumes the whole multiplier, so no low bits survive the shift
    if (MUL_BITS == XLEN) begin : g_mul_full
        assign prod_nxt = mul_acc;
    end else begin : g_mul_part
        assign prod_nxt = {mul_acc, prod_q[XLEN-1:MUL_BITS]};
    end

    // Divide step: DIV_BITS restoring iterations, dividend bits shifted out of quo
    logic [XLEN-1:0] rem_nxt, quo_nxt, div_raw, div_res;
    logic [XLEN:0]   rem_sh, rem_try;

    // Run the restoring iterations and apply the result sign
    always_comb begin
        rem_nxt = rem_q;
        quo_nxt = quo_q;
        rem_sh  = '0;
        rem_try = '0;
        for (int j = 0; j < int'(DIV_BITS); j++) begin
            rem_sh  = {rem_nxt, quo_nxt[XLEN-1]};
            rem_try = rem_sh - {1'b0, dvsr_q};
            // Borrow out means the trial subtraction went negative: restore
            if (!rem_try[XLEN]) begin
                rem_nxt = rem_try[XLEN-1:0];
                quo_nxt = {quo_nxt[XLEN-2:0], 1'b1};
            end else begin
                rem_nxt = rem_sh[XLEN-1:0];
                quo_nxt = {quo_nxt[XLEN-2:0], 1'b0};
            end
        end
        div_raw = op_q[1] ? rem_nxt : quo_nxt;
        div_res = neg_q ? (~div_raw + 1'b1) : div_raw;
    end

    // Control FSM plus the datapath registers it sequences
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= MDU_RESET;
            op_q    <= '0;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            dvsr_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                MDU_RESET: state_q <= MDU_IDLE;
                MDU_IDLE, MDU_DONE: begin
                    if (kill || !reqValid) begin
                        state_q <= MDU_IDLE;
                    end else begin
                        op_q    <= op;
                        neg_q   <= req_neg;
                        mcand_q <= lhs_mag;
                        prod_q  <= {{XLEN{1'b0}}, rhs_mag};
                        dvsr_q  <= rhs_mag;
                        quo_q   <= lhs_mag;
                        rem_q   <= '0;
                        cnt_q   <= op[2] ? CW'(ND - 1) : CW'(NM - 1);
                        if (special) begin
                            state_q <= MDU_DONE;
                            res_q   <= special_res;
                        end else begin
                            state_q <= op[2] ? MDU_DIV : MDU_MUL;
                        end
                    end
                end
                MDU_MUL: begin
                    prod_q <= prod_nxt;
                    if (kill) begin
                        state_q <= MDU_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= MDU_DONE;
                        res_q   <= mul_res;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                MDU_DIV: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    if (kill) begin
                        state_q <= MDU_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= MDU_DONE;
                        res_q   <= div_res;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= MDU_IDLE;
            endcase
        end
    end

    // Outputs decode straight from registered state
    always_comb begin
        reqReady    = (state_q == MDU_IDLE) || (state_q == MDU_DONE);
        respValid   = (state_q == MDU_DONE);
        is_mdu_wait = (state_q == MDU_MUL) || (state_q == MDU_DIV);
        is_mul_seen = respValid & ~op_q[2];
        is_div_seen = respValid & op_q[2];
        res         = res_q;
    end

endmodule

// File: tb/tb_exu_mdu.sv
// Scoreboard bench for exu_mdu: u0 is the bit-serial build and u1 is a faster build
// (4 multiplier bits and 2 quotient bits per cycle).
module tb_exu_mdu;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [1:0]       rv, kl, rr, vv, wt, ms, ds;
    logic [1:0][2:0]  opx;
    logic [1:0][31:0] la, rb, rs;

    exu_mdu #(.XLEN(32), .MUL_BITS(1), .DIV_BITS(1)) u0 (
        .clock(clock), .reset(reset), .reqValid(rv[0]), .reqReady(rr[0]), .kill(kl[0]),
        .op(opx[0]), .lhs(la[0]), .rhs(rb[0]), .respValid(vv[0]), .res(rs[0]),
        .is_mdu_wait(wt[0]), .is_mul_seen(ms[0]), .is_div_seen(ds[0])
    );

    exu_mdu #(.XLEN(32), .MUL_BITS(4), .DIV_BITS(2)) u1 (
        .clock(clock), .reset(reset), .reqValid(rv[1]), .reqReady(rr[1]), .kill(kl[1]),
        .op(opx[1]), .lhs(la[1]), .rhs(rb[1]), .respValid(vv[1]), .res(rs[1]),
        .is_mdu_wait(wt[1]), .is_mul_seen(ms[1]), .is_div_seen(ds[1])
    );

    typedef struct {
        logic [31:0] res;
        int          due;
        bit          is_mul;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    // Cycle number = posedges seen so far
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got no/extra event expected otherwise (cycle %0d)", nm, cyc);
    endtask

    task automatic mon(input int d);
        exp_t e;
        bit   have;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (vv[d]) begin
            if (!have) begin
                fail_now($sformatf("u%0d unexpected respValid", d));
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("u%0d res", d), 64'(rs[d]), 64'(e.res));
                chk($sformatf("u%0d latency", d), 64'(cyc), 64'(e.due));
                chk($sformatf("u%0d is_mul_seen", d), 64'(ms[d]), 64'(e.is_mul));
                chk($sformatf("u%0d is_div_seen", d), 64'(ds[d]), 64'(!e.is_mul));
                chk($sformatf("u%0d reqReady in done", d), 64'(rr[d]), 64'd1);
            end
        end else if (have) begin
            if (d == 0) e = q0[0];
            else        e = q1[0];
            if (cyc > e.due) begin
                fail_now($sformatf("u%0d respValid timeout", d));
                if (d == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    // Monitor: compare every response against the scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            mon(0);
            mon(1);
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic issue(input int d, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input int lat,
                         input bit push, output int t);
        exp_t e;
        int   n = 0;
        while (!rr[d] && n < 200) begin
            step();
            n++;
        end
        if (!rr[d]) fail_now($sformatf("u%0d reqReady timeout", d));
        rv[d]  = 1'b1;
        opx[d] = o;
        la[d]  = a;
        rb[d]  = b;
        t      = cyc;
        if (push) begin
            e.res    = er;
            e.due    = cyc + lat;
            e.is_mul = !o[2];
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        step();
        rv[d] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 1000) begin
            step();
            n++;
        end
        if (q0.size() > 0 || q1.size() > 0) fail_now("drain timeout");
        step();
    endtask

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    initial begin
        int t;
        int bad;
        logic [31:0] prev;
        rv = '0; kl = '0; opx = '0; la = '0; rb = '0;
        reset = 1'b1;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("u%0d reset reqReady", d), 64'(rr[d]), 64'd0);
            chk($sformatf("u%0d reset respValid", d), 64'(vv[d]), 64'd0);
            chk($sformatf("u%0d reset res", d), 64'(rs[d]), 64'd0);
            chk($sformatf("u%0d reset perf", d), 64'({wt[d], ms[d], ds[d]}), 64'd0);
        end
        reset = 1'b0;
        chk("reqReady in RESET state", 64'(rr[0]), 64'd0);
        step();
        chk("reqReady after RESET state", 64'(rr[0]), 64'd1);

        // First multiply: busy window and exact latency
        issue(0, MUL, 32'd7, 32'd6, 32'd42, 33, 1'b1, t);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (rr[0] !== 1'b0 || wt[0] !== 1'b1) bad++;
            step();
        end
        chk("busy window cycles with reqReady/!wait", 64'(bad), 64'd0);

        // Directed multiply/divide vectors, issued back to back
        issue(0, MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 1'b1, t);
        issue(0, MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b1, t);
        issue(0, MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33, 1'b1, t);
        issue(0, MUL,    32'h12345678, 32'h00000010, 32'h23456780, 33, 1'b1, t);
        issue(0, MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b1, t);
        issue(0, DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, 1'b1, t);
        issue(0, REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, 1'b1, t);
        issue(0, DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 1'b1, t);
        issue(0, REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33, 1'b1, t);
        issue(0, DIVU,   32'd100,      32'd7,        32'd14,       33, 1'b1, t);
        issue(0, REMU,   32'd100,      32'd7,        32'd2,        33, 1'b1, t);
        issue(0, DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b1, t);
        issue(0, REMU,   32'd5,        32'd0,        32'd5,        1,  1'b1, t);
        issue(0, DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b1, t);
        issue(0, REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  1'b1, t);
        issue(0, DIV,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1,  1'b1, t);
        issue(0, REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1,  1'b1, t);

        // Faster build: 8-cycle multiply, 16-cycle divide
        issue(1, MUL,   32'd7,        32'd6,        32'd42,       9,  1'b1, t);
        issue(1, MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 9,  1'b1, t);
        issue(1, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 9,  1'b1, t);
        issue(1, DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 17, 1'b1, t);
        issue(1, REM,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 17, 1'b1, t);
        issue(1, DIVU,  32'd100,      32'd7,        32'd14,       17, 1'b1, t);
        issue(1, DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b1, t);
        wait_idle();

        // Kill mid-divide: aborted with no response and res untouched
        prev = 32'hFFFFFFF9;
        issue(0, DIV, 32'd100, 32'd3, 32'd0, 0, 1'b0, t);
        while (cyc < t + 10) step();
        kl[0] = 1'b1;
        step();
        kl[0] = 1'b0;
        chk("idle after kill reqReady", 64'(rr[0]), 64'd1);
        chk("idle after kill wait", 64'(wt[0]), 64'd0);
        chk("res held after kill", 64'(rs[0]), 64'(prev));

        // Request together with kill is dropped
        rv[0] = 1'b1; kl[0] = 1'b1; opx[0] = MUL; la[0] = 32'd2; rb[0] = 32'd2;
        step();
        rv[0] = 1'b0; kl[0] = 1'b0;
        chk("killed request dropped", 64'({rr[0], wt[0]}), 64'b10);

        // Next op: old res holds through the busy cycles
        issue(0, MUL, 32'd3, 32'd3, 32'd9, 33, 1'b1, t);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (rs[0] !== prev) bad++;
            step();
        end
        chk("res held during busy cycles", 64'(bad), 64'd0);
        wait_idle();

        // Kill during DONE: response still pulses, new request dropped
        issue(0, DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 1, 1'b1, t);
        rv[0] = 1'b1; kl[0] = 1'b1; opx[0] = MUL; la[0] = 32'd4; rb[0] = 32'd4;
        step();
        rv[0] = 1'b0; kl[0] = 1'b0;
        chk("request dropped by kill in DONE", 64'({rr[0], wt[0]}), 64'b10);
        wait_idle();

        // Reset mid-multiply: immediate abort
        issue(0, MUL, 32'd5, 32'd5, 32'd0, 0, 1'b0, t);
        while (cyc < t + 5) step();
        reset = 1'b1;
        #1;
        chk("reset mid-op reqReady", 64'(rr[0]), 64'd0);
        chk("reset mid-op respValid", 64'(vv[0]), 64'd0);
        chk("reset mid-op wait", 64'(wt[0]), 64'd0);
        step();
        reset = 1'b0;
        chk("reqReady right after release", 64'(rr[0]), 64'd0);
        step();
        chk("reqReady one edge after release", 64'(rr[0]), 64'd1);
        chk("res cleared by reset", 64'(rs[0]), 64'd0);
        issue(0, MULHU, 32'h80000000, 32'd4, 32'd2, 33, 1'b1, t);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
